// File: rtl/spn_cipher_pkg.sv
// Shared types, S-box tables and width-generic substitution/permutation layers
// for the iterative SPN cipher core. Layers work on a 128-bit carrier; bits at and above w are zero.
package spn_cipher_pkg;

    typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} state_t;

    localparam logic [3:0] SBOX [16] = '{
        4'h1, 4'hA, 4'h4, 4'hC, 4'h6, 4'hF, 4'h3, 4'h9,
        4'h2, 4'hD, 4'hB, 4'h7, 4'h5, 4'h0, 4'h8, 4'hE
    };
    localparam logic [3:0] SBOX_INV [16] = '{
        4'hD, 4'h0, 4'h8, 4'h6, 4'h2, 4'hC, 4'h4, 4'hB,
        4'hE, 4'h7, 4'h1, 4'hA, 4'h3, 4'h9, 4'hF, 4'h5
    };

    localparam int P_MUL    = 17;
    localparam int PINV_64  = 49;
    localparam int PINV_128 = 113;

    function automatic int pinv(input int w);
        return (w == 128) ? PINV_128 : PINV_64;
    endfunction

    function automatic logic [127:0] sub_layer(input logic [127:0] x, input int w);
        logic [127:0] y;
        logic [6:0]   b;
        y = '0;
        for (int n = 0; n < 32; n++) begin
            b = 7'(4 * n);
            if (n < w / 4) y[b +: 4] = SBOX[x[b +: 4]];
        end
        return y;
    endfunction

    function automatic logic [127:0] inv_sub_layer(input logic [127:0] x, input int w);
        logic [127:0] y;
        logic [6:0]   b;
        y = '0;
        for (int n = 0; n < 32; n++) begin
            b = 7'(4 * n);
            if (n < w / 4) y[b +: 4] = SBOX_INV[x[b +: 4]];
        end
        return y;
    endfunction

    // out[j] = in[(mul*j) mod w]; shared by the forward and inverse permutations.
    function automatic logic [127:0] bit_gather(input logic [127:0] x, input int w, input int mul);
        logic [127:0] y;
        y = '0;
        for (int j = 0; j < 128; j++) begin
            if (j < w) y[7'(j)] = x[7'((mul * j) % w)];
        end
        return y;
    endfunction

    function automatic logic [127:0] perm(input logic [127:0] x, input int w);
        return bit_gather(x, w, P_MUL);
    endfunction

    function automatic logic [127:0] inv_perm(input logic [127:0] x, input int w);
        return bit_gather(x, w, pinv(w));
    endfunction

endpackage

// File: rtl/spn_round.sv
// One combinational SPN round; the encrypt and decrypt datapaths are both built and selected by mode.
module spn_round
    import spn_cipher_pkg::*;
#(
    parameter int BLOCK_W = 64
) (
    input  logic [BLOCK_W-1:0] state,
    input  logic [BLOCK_W-1:0] rkey,
    input  logic [5:0]         rnd,
    input  logic               decrypt,
    output logic [BLOCK_W-1:0] next_state
);

    logic [BLOCK_W-1:0] rc;
    logic [BLOCK_W-1:0] enc_state;
    logic [BLOCK_W-1:0] dec_state;

    assign rc = {{(BLOCK_W-6){1'b0}}, rnd};

    // Decrypt undoes the encrypt round in reverse order: key/constant first, then P^-1, then S^-1.
    assign enc_state = BLOCK_W'(perm(sub_layer(128'(state), BLOCK_W), BLOCK_W)) ^ rkey ^ rc;
    assign dec_state = BLOCK_W'(inv_sub_layer(inv_perm(128'(state ^ rkey ^ rc), BLOCK_W), BLOCK_W));

    assign next_state = decrypt ? dec_state : enc_state;

endmodule

// File: rtl/spn_cipher_iter.sv
// Iterative SPN cipher core, one round per clock on valid/ready streams.
// Decrypt first rolls the key forward to the last round key, then walks it back with rotr.
module spn_cipher_iter
    import spn_cipher_pkg::*;
#(
    parameter int BLOCK_W = 64,
    parameter int ROUNDS  = 28,
    parameter int KEY_ROT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_decrypt,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic [127:0]       in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               busy
);

    localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);
    localparam logic [5:0] PRE_LAST = 6'(ROUNDS - 2);

    state_t             state_reg, state_next;
    logic [BLOCK_W-1:0] data_reg, data_next, round_out;
    logic [127:0]       key_reg, key_next, key_rotl, key_rotr;
    logic [5:0]         rnd_reg, rnd_next;
    logic               dec_reg, dec_next;

    assign key_rotl = {key_reg[127-KEY_ROT:0], key_reg[127:128-KEY_ROT]};
    assign key_rotr = {key_reg[KEY_ROT-1:0], key_reg[127:KEY_ROT]};

    spn_round #(.BLOCK_W(BLOCK_W)) u_round (
        .state      (data_reg),
        .rkey       (key_reg[BLOCK_W-1:0]),
        .rnd        (rnd_reg),
        .decrypt    (dec_reg),
        .next_state (round_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            key_reg   <= '0;
            rnd_reg   <= '0;
            dec_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            key_reg   <= key_next;
            rnd_reg   <= rnd_next;
            dec_reg   <= dec_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        key_next   = key_reg;
        rnd_next   = rnd_reg;
        dec_next   = dec_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    data_next  = in_data;
                    key_next   = in_key;
                    dec_next   = in_decrypt;
                    rnd_next   = '0;
                    state_next = (in_decrypt && ROUNDS > 1) ? EXPAND : ROUND;
                end
            end
            EXPAND: begin
                key_next = key_rotl;
                rnd_next = rnd_reg + 6'd1;
                if (rnd_reg == PRE_LAST) state_next = ROUND;
            end
            ROUND: begin
                data_next = round_out;
                if (!dec_reg) begin
                    key_next = key_rotl;
                    rnd_next = rnd_reg + 6'd1;
                    if (rnd_reg == LAST_RND) state_next = DONE;
                end else begin
                    key_next = key_rotr;
                    rnd_next = rnd_reg - 6'd1;
                    if (rnd_reg == 6'd0) state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign out_data  = data_reg;

endmodule

// File: tb/tb_spn_cipher_iter.sv
// Bench for spn_cipher_iter: three instances (64/1, 64/28, 128/40) checked against a behavioural model.
module tb_spn_cipher_iter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid   [3];
    logic         in_ready   [3];
    logic         in_decrypt [3];
    logic         out_valid  [3];
    logic         out_ready  [3];
    logic         busy       [3];
    logic [127:0] in_data_u  [3];
    logic [127:0] in_key_u   [3];
    logic [127:0] out_data_u [3];
    logic [63:0]  out0, out1;
    logic [127:0] out2;

    assign out_data_u[0] = {64'h0, out0};
    assign out_data_u[1] = {64'h0, out1};
    assign out_data_u[2] = out2;

    spn_cipher_iter #(.BLOCK_W(64), .ROUNDS(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_decrypt(in_decrypt[0]), .in_data(in_data_u[0][63:0]), .in_key(in_key_u[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out0), .busy(busy[0]));

    spn_cipher_iter u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_decrypt(in_decrypt[1]), .in_data(in_data_u[1][63:0]), .in_key(in_key_u[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out1), .busy(busy[1]));

    spn_cipher_iter #(.BLOCK_W(128), .ROUNDS(40)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_decrypt(in_decrypt[2]), .in_data(in_data_u[2]), .in_key(in_key_u[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out2), .busy(busy[2]));

    localparam logic [3:0] TB_S [16] = '{
        4'h1, 4'hA, 4'h4, 4'hC, 4'h6, 4'hF, 4'h3, 4'h9,
        4'h2, 4'hD, 4'hB, 4'h7, 4'h5, 4'h0, 4'h8, 4'hE
    };

    typedef struct {
        int           u;
        logic         dec;
        logic [127:0] data;
        logic [127:0] key;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    typedef struct {
        logic [127:0] data;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [3:0] s_inv(input logic [3:0] v);
        for (int n = 0; n < 16; n++) if (TB_S[n] == v) return 4'(n);
        return 4'h0;
    endfunction

    // Reference cipher; decrypt inverts P by scattering through the forward map.
    function automatic logic [127:0] model(input logic dec, input logic [127:0] x,
                                           input logic [127:0] k, input int w, input int rounds);
        logic [127:0] rk [64];
        logic [127:0] s, t, u, mask;
        logic [6:0]   a, b;
        mask = (w == 128) ? {128{1'b1}} : {64'h0, {64{1'b1}}};
        rk[0] = k;
        for (int i = 1; i < rounds; i++) rk[6'(i)] = {rk[6'(i - 1)][95:0], rk[6'(i - 1)][127:96]};
        s = x & mask;
        if (!dec) begin
            for (int i = 0; i < rounds; i++) begin
                t = '0;
                for (int n = 0; n < w / 4; n++) begin
                    b = 7'(4 * n);
                    t[b +: 4] = TB_S[s[b +: 4]];
                end
                u = '0;
                for (int j = 0; j < w; j++) begin
                    a = 7'(j);
                    b = 7'((17 * j) % w);
                    u[a] = t[b];
                end
                s = (u ^ rk[6'(i)] ^ 128'(i)) & mask;
            end
        end else begin
            for (int i = rounds - 1; i >= 0; i--) begin
                t = (s ^ rk[6'(i)] ^ 128'(i)) & mask;
                u = '0;
                for (int j = 0; j < w; j++) begin
                    a = 7'(j);
                    b = 7'((17 * j) % w);
                    u[b] = t[a];
                end
                s = '0;
                for (int n = 0; n < w / 4; n++) begin
                    b = 7'(4 * n);
                    s[b +: 4] = s_inv(u[b +: 4]);
                end
            end
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic launch(input int u, input logic dec, input logic [127:0] d, input logic [127:0] k);
        @(negedge clk);
        check("in_ready_idle", 128'(in_ready[u]), 128'(1));
        in_valid[u]   = 1'b1;
        in_decrypt[u] = dec;
        in_data_u[u]  = d;
        in_key_u[u]   = k;
        @(posedge clk);
        #1;
        in_valid[u]   = 1'b0;
        in_decrypt[u] = ~dec;
        in_data_u[u]  = ~d;
        in_key_u[u]   = ~k;
    endtask

    task automatic wait_valid(input int u, output int lat);
        lat = 0;
        while (!out_valid[u] && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input int u, input logic dec, input logic [127:0] d, input logic [127:0] k,
                          input logic [127:0] exp, input int exp_lat, input string name);
        exp_t e;
        int   lat;
        e.data = exp;
        e.lat  = exp_lat;
        launch(u, dec, d, k);
        sb.push_back(e);
        wait_valid(u, lat);
        e = sb.pop_front();
        if (!out_valid[u]) begin
            check({name, "_timeout"}, 128'(out_valid[u]), 128'(1));
        end else begin
            check({name, "_data"}, out_data_u[u], e.data);
            check({name, "_latency"}, 128'(lat), 128'(e.lat));
        end
        $display("op %s u%0d dec=%0d lat=%0d out=%h", name, u, dec, lat, out_data_u[u]);
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] KEY_SEQ = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] PT_REF  = 128'h0123456789ABCDEF;

    initial begin
        vec_t         vt [4];
        logic [127:0] d, k, e;
        int           lat;

        for (int u = 0; u < 3; u++) begin
            in_valid[u] = 1'b0; in_decrypt[u] = 1'b0; out_ready[u] = 1'b1;
            in_data_u[u] = '0; in_key_u[u] = '0;
        end
        rst = 1'b1;
        #12;
        for (int u = 0; u < 3; u++) begin
            check("rst_in_ready", 128'(in_ready[u]), 128'(1));
            check("rst_out_valid", 128'(out_valid[u]), 128'(0));
            check("rst_busy", 128'(busy[u]), 128'(0));
            check("rst_out_data", out_data_u[u], 128'(0));
        end
        @(negedge clk);
        rst = 1'b0;

        vt[0] = '{u: 0, dec: 1'b0, data: 128'h0, key: 128'h0,
                  exp: 128'h1111111111111111, lat: 1};
        vt[1] = '{u: 0, dec: 1'b1, data: 128'h1111111111111111, key: 128'h0,
                  exp: 128'h0, lat: 1};
        vt[2] = '{u: 1, dec: 1'b0, data: PT_REF, key: KEY_SEQ,
                  exp: model(1'b0, PT_REF, KEY_SEQ, 64, 28), lat: 28};
        vt[3] = '{u: 1, dec: 1'b1, data: vt[2].exp, key: KEY_SEQ,
                  exp: PT_REF, lat: 55};
        for (int i = 0; i < 4; i++)
            run_op(vt[i].u, vt[i].dec, vt[i].data, vt[i].key, vt[i].exp, vt[i].lat, $sformatf("vec%0d", i));

        // Back-pressure: result held in DONE, new requests ignored.
        d = 128'hDEADBEEFCAFEF00D;
        e = model(1'b0, d, KEY_SEQ, 64, 28);
        out_ready[1] = 1'b0;
        launch(1, 1'b0, d, KEY_SEQ);
        wait_valid(1, lat);
        check("bp_latency", 128'(lat), 128'(28));
        check("bp_data", out_data_u[1], e);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid[1]   = 1'b1;
            in_decrypt[1] = 1'b1;
            in_data_u[1]  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            check("bp_hold_valid", 128'(out_valid[1]), 128'(1));
            check("bp_hold_data", out_data_u[1], e);
            check("bp_hold_in_ready", 128'(in_ready[1]), 128'(0));
        end
        @(negedge clk);
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 128'(in_ready[1]), 128'(1));
        check("bp_release_out_valid", 128'(out_valid[1]), 128'(0));
        check("bp_release_busy", 128'(busy[1]), 128'(0));
        $display("op backpressure u1 out=%h", e);

        // Asynchronous reset in the middle of the round loop.
        launch(1, 1'b0, PT_REF, KEY_SEQ);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 128'(out_valid[1]), 128'(0));
        check("mid_rst_in_ready", 128'(in_ready[1]), 128'(1));
        check("mid_rst_busy", 128'(busy[1]), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        run_op(1, 1'b0, 128'h00FF00FF12345678, KEY_SEQ,
               model(1'b0, 128'h00FF00FF12345678, KEY_SEQ, 64, 28), 28, "after_rst");

        for (int r = 0; r < 200; r++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            e = model(1'b0, d, k, 128, 40);
            run_op(2, 1'b0, d, k, e, 40, "rnd_enc");
            run_op(2, 1'b1, e, k, d, 79, "rnd_dec");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
